// File: rtl/adder_serial_pkg.sv
// Shared constants and types for the nibble-serial add/subtract unit.
package adder_serial_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slice counter width; a single-bit counter is the floor even for tiny slice counts.
  function automatic int cnt_width(input int n_slices);
    return (n_slices <= 1) ? 1 : $clog2(n_slices);
  endfunction

endpackage

// File: rtl/adder_serial_adder.sv
// 74283-style 4-bit binary full adder with fast carry, used as the serial slice adder.
module ttl_74283
  import adder_serial_pkg::*;
#(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               C_in,
  output logic [SLICE_W-1:0] Sum,
  output logic               C_out
);

  // Timing parameters only shape the gate-level model; reject nonsense values here.
  generate
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
      $error("ttl_74283: delays must be non-negative");
    end
  endgenerate

  assign {C_out, Sum} = {1'b0, A} + {1'b0, B} + {{SLICE_W{1'b0}}, C_in};

endmodule

// File: rtl/adder_serial.sv
// Multi-cycle WIDTH-bit add/subtract: one 4-bit slice per clock through a single 74283,
// with a carry flip-flop between slices and a start/busy/done handshake.
module adder_serial
  import adder_serial_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             CLK,
  input  logic             RST_bar,
  input  logic             START,
  input  logic             SUBTRACT,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  input  logic             CARRY_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY_OUT,
  output logic             OVERFLOW,
  output logic             ZERO
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int CNT_W = cnt_width(N);
  localparam int SR_W  = WIDTH - SLICE_W;

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("adder_serial: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    res_sr_q, res_sr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               msb_carry;
  logic [WIDTH-1:0]   final_result;

  ttl_74283 #(
    .DELAY_RISE(DELAY_RISE),
    .DELAY_FALL(DELAY_FALL)
  ) u_slice_adder (
    .A    (a_q[SLICE_W-1:0]),
    .B    (b_q[SLICE_W-1:0]),
    .C_in (carry_q),
    .Sum  (slice_sum),
    .C_out(slice_cout)
  );

  // Carry into the slice MSB, recovered from its sum bit; meaningful on the last slice.
  assign msb_carry    = a_q[SLICE_W-1] ^ b_q[SLICE_W-1] ^ slice_sum[SLICE_W-1];
  assign final_result = {slice_sum, res_sr_q};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_sr_d    = res_sr_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = LHS;
          b_d     = SUBTRACT ? ~RHS : RHS;
          carry_d = CARRY_IN;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> SLICE_W;
        b_d      = b_q >> SLICE_W;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + 1'b1;
        res_sr_d = final_result[WIDTH-1:SLICE_W];
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          result_d    = final_result;
          carry_out_d = slice_cout;
          overflow_d  = msb_carry ^ slice_cout;
          zero_d      = (final_result == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_sr_q    <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_sr_q    <= res_sr_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign CARRY_OUT = carry_out_q;
  assign OVERFLOW  = overflow_q;
  assign ZERO      = zero_q;

endmodule
